// File: rtl/ip_codma_crc_feeder.sv
// CODMA CRC feeder: packs up to WORDS read beats into a block, kicks the CRC engine and returns the result.
// Optional build macro CODMA_CRC_FEED_BSWAP_EN byte-reverses each beat before it is stored.
module ip_codma_crc_feeder #(
  parameter int WORDS          = 8,
  parameter int DW             = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  input  logic                        rd_valid_i,
  input  logic [DW-1:0]               rd_data_i,
  input  logic                        rd_last_i,
  output logic                        rd_ready_o,
  output logic                        crc_start_o,
  output logic [WORDS-1:0][DW-1:0]    data_reg_o,
  input  logic                        crc_complete_i,
  input  logic [15:0]                 crc_result_i,
  output logic                        res_valid_o,
  output logic [15:0]                 res_crc_o,
  output logic [$clog2(WORDS):0]      res_words_o,
  output logic                        res_err_o,
  input  logic                        res_ready_i,
  output logic                        busy_o
);

  localparam int CW = $clog2(WORDS) + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

  typedef enum logic [2:0] {S_IDLE, S_FILL, S_KICK, S_WAIT, S_RESULT} state_t;

  state_t        state_reg;
  logic [CW-1:0] count_reg;
  logic [TW-1:0] timer_reg;
  logic          rd_ready_reg;
  logic          crc_start_reg;
  logic          res_valid_reg;
  logic          res_err_reg;
  logic [15:0]   res_crc_reg;
  logic [CW-1:0] res_words_reg;
  logic [DW-1:0] beat_data;
  logic          accept;
  logic          release_blk;

  // rd_ready_reg is only ever high in IDLE/FILL, so it alone qualifies a beat.
  assign accept      = rd_valid_i & rd_ready_reg;
  assign release_blk = (state_reg == S_RESULT) & res_ready_i;

  genvar gi;

`ifdef CODMA_CRC_FEED_BSWAP_EN
  generate
    for (gi = 0; gi < DW/8; gi++) begin : g_bswap
      assign beat_data[gi*8 +: 8] = rd_data_i[DW-8-gi*8 +: 8];
    end
  endgenerate
`else
  assign beat_data = rd_data_i;
`endif

  // One register per block word; unwritten words keep their cleared value as zero pad.
  generate
    for (gi = 0; gi < WORDS; gi++) begin : g_word
      logic [DW-1:0] word_reg;
      always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
          word_reg <= '0;
        end else if (release_blk) begin
          word_reg <= '0;
        end else if (accept && (count_reg == CW'(gi))) begin
          word_reg <= beat_data;
        end
      end
      assign data_reg_o[gi] = word_reg;
    end
  endgenerate

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_reg     <= S_IDLE;
      count_reg     <= '0;
      timer_reg     <= '0;
      rd_ready_reg  <= 1'b0;
      crc_start_reg <= 1'b0;
      res_valid_reg <= 1'b0;
      res_err_reg   <= 1'b0;
      res_crc_reg   <= '0;
      res_words_reg <= '0;
    end else begin
      case (state_reg)
        S_IDLE, S_FILL: begin
          rd_ready_reg <= 1'b1;
          if (accept) begin
            count_reg <= count_reg + 1'b1;
            if (rd_last_i || (count_reg == CW'(WORDS-1))) begin
              state_reg     <= S_KICK;
              rd_ready_reg  <= 1'b0;
              crc_start_reg <= 1'b1;
            end else begin
              state_reg <= S_FILL;
            end
          end
        end
        S_KICK: begin
          crc_start_reg <= 1'b0;
          timer_reg     <= '0;
          state_reg     <= S_WAIT;
        end
        S_WAIT: begin
          // Completion is checked first so it wins over a simultaneous expiry.
          if (crc_complete_i) begin
            res_crc_reg   <= crc_result_i;
            res_err_reg   <= 1'b0;
            res_words_reg <= count_reg;
            res_valid_reg <= 1'b1;
            state_reg     <= S_RESULT;
          end else if (timer_reg == TW'(TIMEOUT_CYCLES-1)) begin
            res_crc_reg   <= '0;
            res_err_reg   <= 1'b1;
            res_words_reg <= count_reg;
            res_valid_reg <= 1'b1;
            state_reg     <= S_RESULT;
          end else begin
            timer_reg <= timer_reg + 1'b1;
          end
        end
        S_RESULT: begin
          if (res_ready_i) begin
            res_valid_reg <= 1'b0;
            count_reg     <= '0;
            rd_ready_reg  <= 1'b1;
            state_reg     <= S_IDLE;
          end
        end
        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  assign rd_ready_o  = rd_ready_reg;
  assign crc_start_o = crc_start_reg;
  assign res_valid_o = res_valid_reg;
  assign res_crc_o   = res_crc_reg;
  assign res_words_o = res_words_reg;
  assign res_err_o   = res_err_reg;
  assign busy_o      = (state_reg != S_IDLE);

endmodule
